// File: rtl/accum_sched_pkg.sv
// rtl/accum_sched_pkg.sv - shared FSM state type and id-width helper for accum_sched
package accum_sched_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC    = 2'd1,
      RESULT = 2'd2
   } state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/accum_sched_if.sv
// rtl/accum_sched_if.sv - requester operand streams and result port of accum_sched
interface accum_sched_if #(
   parameter int N  = 4,
   parameter int DW = 8
) ();
   import accum_sched_pkg::*;

   localparam int IW = id_width(N);

   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            res_valid;
   logic            res_ready;
   logic [DW-1:0]   res_data;
   logic [IW-1:0]   res_id;
   logic            busy;

   modport master (
      output req_valid, req_last, req_data, res_ready,
      input  req_ready, res_valid, res_data, res_id, busy
   );

   modport slave (
      input  req_valid, req_last, req_data, res_ready,
      output req_ready, res_valid, res_data, res_id, busy
   );

endinterface

// File: rtl/accum_sched_rr_arbiter.sv
// rtl/accum_sched_rr_arbiter.sv - combinational round-robin pick starting after i_ptr
module rr_arbiter
   import accum_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]            i_req,
   input  logic [id_width(N)-1:0]  i_ptr,
   output logic [id_width(N)-1:0]  o_gnt_idx,
   output logic                    o_any_req
);
   localparam int IW = id_width(N);

   int w_idx;

   // Walk offsets from farthest to nearest so the nearest valid requester wins last.
   always_comb begin
      o_gnt_idx = '0;
      o_any_req = 1'b0;
      w_idx     = 0;
      for (int off = N; off >= 1; off--) begin
         w_idx = (int'(i_ptr) + off) % N;
         if (i_req[w_idx]) begin
            o_gnt_idx = IW'(w_idx);
            o_any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/accum_sched.sv
// rtl/accum_sched.sv - one DW-bit accumulator shared among N burst requesters
module accum_sched
   import accum_sched_pkg::*;
#(
   parameter int N  = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   accum_sched_if.slave  bus
);
   localparam int IW = id_width(N);

   state_t          r_state;
   state_t          w_next;
   logic [DW-1:0]   r_acc;
   logic [DW-1:0]   r_res_data;
   logic [IW-1:0]   r_res_id;
   logic [IW-1:0]   r_grant;
   logic [IW-1:0]   r_rr_ptr;
   logic [IW-1:0]   w_gnt_idx;
   logic            w_any_req;
   logic            w_beat;
   logic            w_last;
   logic [DW-1:0]   w_operand;
   logic [DW-1:0]   w_sum;

   rr_arbiter #(.N(N)) u_arb (
      .i_req     (bus.req_valid),
      .i_ptr     (r_rr_ptr),
      .o_gnt_idx (w_gnt_idx),
      .o_any_req (w_any_req)
   );

   assign w_operand    = bus.req_data[r_grant*DW +: DW];
   assign w_beat       = (r_state == ACC) && bus.req_valid[r_grant];
   assign w_last       = bus.req_last[r_grant];
   assign w_sum        = r_acc + w_operand;
   assign bus.res_data = r_res_data;
   assign bus.res_id   = r_res_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      bus.req_ready = '0;
      bus.res_valid = 1'b0;
      bus.busy      = 1'b1;
      case (r_state)
         IDLE: begin
            bus.busy = 1'b0;
            if (w_any_req) w_next = ACC;
         end
         ACC: begin
            bus.req_ready[r_grant] = 1'b1;
            if (w_beat && w_last) w_next = RESULT;
         end
         RESULT: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // The rotation pointer only advances once the result is taken, so a stalled
   // consumer cannot let the next requester jump ahead.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc      <= '0;
         r_grant    <= '0;
         r_rr_ptr   <= IW'(N-1);
         r_res_data <= '0;
         r_res_id   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_grant <= w_gnt_idx;
                  r_acc   <= '0;
               end
            end
            ACC: begin
               if (w_beat) begin
                  r_acc <= w_sum;
                  if (w_last) begin
                     r_res_data <= w_sum;
                     r_res_id   <= r_grant;
                  end
               end
            end
            RESULT: begin
               if (bus.res_ready) r_rr_ptr <= r_grant;
            end
            default: ;
         endcase
      end
   end

endmodule
